// File: rtl/session_key_vault.sv
// Session key vault: captures the KDF session key on a rising kdf_complete, serves it as
// words, expires it after a lifetime and erases it one word per cycle.
module session_key_vault #(
    parameter int unsigned KEY_W           = 384,
    parameter int unsigned WORD_W          = 32,
    parameter int unsigned LIFETIME_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              kdf_complete,
    input  logic [KEY_W-1:0]  kdf_session_key,
    input  logic              zeroize,
    input  logic              rd_req,
    input  logic [3:0]        rd_idx,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_err,
    output logic              key_valid,
    output logic [7:0]        key_epoch,
    output logic              expired
);

    localparam int unsigned NWORDS    = KEY_W / WORD_W;
    localparam logic [3:0]  LAST_IDX  = 4'(NWORDS - 1);
    localparam logic [31:0] LIFE_LAST = 32'(LIFETIME_CYCLES - 1);
    localparam bit          LIFE_ON   = (LIFETIME_CYCLES != 0);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        LOADED    = 2'd1,
        ZEROIZING = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] key_mem [NWORDS];
    logic              complete_prev;
    logic              load_event;
    logic              pending;
    logic              pending_nxt;
    logic [31:0]       life_ctr;
    logic [3:0]        zidx;
    logic              do_load;
    logic              do_clear;
    logic              expire_now;
    logic              rd_bad;
    logic [WORD_W-1:0] rd_word;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign load_event = kdf_complete & ~complete_prev;
    assign key_valid  = (state == LOADED);

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        do_load     = 1'b0;
        do_clear    = 1'b0;
        expire_now  = 1'b0;
        case (state)
            EMPTY: begin
                if (load_event) begin
                    do_load   = 1'b1;
                    state_nxt = LOADED;
                end
            end
            LOADED: begin
                if (zeroize) begin
                    state_nxt = ZEROIZING;
                    if (load_event) pending_nxt = 1'b1;
                end else if (LIFE_ON && (life_ctr == LIFE_LAST)) begin
                    expire_now = 1'b1;
                    state_nxt  = ZEROIZING;
                    if (load_event) pending_nxt = 1'b1;
                end else if (load_event) begin
                    do_load = 1'b1;
                end
            end
            ZEROIZING: begin
                do_clear = 1'b1;
                if (load_event) pending_nxt = 1'b1;
                if (zidx == LAST_IDX) begin
                    // A deferred load only happens if the KDF result is still being presented.
                    state_nxt   = EMPTY;
                    pending_nxt = 1'b0;
                    if ((pending || load_event) && kdf_complete) begin
                        do_load   = 1'b1;
                        state_nxt = LOADED;
                    end
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= EMPTY;
            complete_prev <= 1'b0;
            pending       <= 1'b0;
            life_ctr      <= '0;
            zidx          <= '0;
            key_epoch     <= '0;
            expired       <= 1'b0;
        end else begin
            state         <= state_nxt;
            complete_prev <= kdf_complete;
            pending       <= pending_nxt;
            expired       <= expire_now;
            if (do_load) begin
                key_epoch <= key_epoch + 8'd1;
                life_ctr  <= '0;
            end else if (state == LOADED) begin
                life_ctr  <= sat_inc(life_ctr);
            end
            if (state == ZEROIZING && zidx != LAST_IDX) zidx <= zidx + 4'd1;
            else                                        zidx <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NWORDS; i++) key_mem[i] <= '0;
        end else if (do_load) begin
            for (int i = 0; i < NWORDS; i++)
                key_mem[i] <= kdf_session_key[KEY_W-1-i*WORD_W -: WORD_W];
        end else if (do_clear) begin
            key_mem[zidx] <= '0;
        end
    end

    // Read port sees state and storage before this cycle's load or clear takes effect.
    assign rd_bad  = (state != LOADED) || (rd_idx > LAST_IDX);
    assign rd_word = (rd_idx <= LAST_IDX) ? key_mem[rd_idx] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            rd_err   <= rd_req && rd_bad;
            rd_data  <= (rd_req && !rd_bad) ? rd_word : '0;
        end
    end

endmodule

// File: tb/tb_session_key_vault.sv
// Directed bench for session_key_vault: one default-lifetime instance and one with a
// 20-cycle lifetime, both driven by the same stimulus.
module tb_session_key_vault;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         kdf_complete;
    logic [383:0] kdf_session_key;
    logic         zeroize;
    logic         rd_req;
    logic [3:0]   rd_idx;

    logic        rd_valid, rd_err, key_valid, expired;
    logic [31:0] rd_data;
    logic [7:0]  key_epoch;
    logic        rd_valid_l, rd_err_l, key_valid_l, expired_l;
    logic [31:0] rd_data_l;
    logic [7:0]  key_epoch_l;

    int total = 0;
    int bad   = 0;
    logic [383:0] key1;
    logic [383:0] key2;

    session_key_vault dut (
        .clk(clk), .reset_n(reset_n), .kdf_complete(kdf_complete),
        .kdf_session_key(kdf_session_key), .zeroize(zeroize), .rd_req(rd_req),
        .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .key_valid(key_valid), .key_epoch(key_epoch), .expired(expired)
    );

    session_key_vault #(.LIFETIME_CYCLES(20)) dut_l (
        .clk(clk), .reset_n(reset_n), .kdf_complete(kdf_complete),
        .kdf_session_key(kdf_session_key), .zeroize(zeroize), .rd_req(rd_req),
        .rd_idx(rd_idx), .rd_valid(rd_valid_l), .rd_data(rd_data_l), .rd_err(rd_err_l),
        .key_valid(key_valid_l), .key_epoch(key_epoch_l), .expired(expired_l)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        for (int i = 0; i < 48; i++) key1[383-8*i -: 8] = 8'(i + 1);
        key2 = ~key1;
        reset_n = 1'b0; kdf_complete = 1'b0; kdf_session_key = '0;
        zeroize = 1'b0; rd_req = 1'b0; rd_idx = '0;
        tick(); tick();
        chk("reset_key_valid", 32'(key_valid), 32'd0);
        chk("reset_epoch", 32'(key_epoch), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_expired", 32'(expired), 32'd0);
        reset_n = 1'b1;
        tick();

        // first load and read of word 0
        kdf_session_key = key1; kdf_complete = 1'b1;
        tick();
        chk("load1_valid", 32'(key_valid), 32'd1);
        chk("load1_epoch", 32'(key_epoch), 32'd1);
        rd_req = 1'b1; rd_idx = 4'd0;
        tick();
        rd_req = 1'b0;
        chk("load1_rd_valid", 32'(rd_valid), 32'd1);
        chk("load1_rd_data", rd_data, 32'h01020304);
        chk("load1_rd_err", 32'(rd_err), 32'd0);
        tick();
        chk("idle_rd_valid", 32'(rd_valid), 32'd0);

        // level held does not reload; new rising edge does
        repeat (50) tick();
        chk("hold_epoch", 32'(key_epoch), 32'd1);
        kdf_complete = 1'b0;
        tick();
        kdf_session_key = key2; kdf_complete = 1'b1;
        tick();
        chk("load2_epoch", 32'(key_epoch), 32'd2);
        rd_req = 1'b1; rd_idx = 4'd11;
        tick();
        chk("load2_rd_w11", rd_data, 32'hd2d1d0cf);

        // out-of-range index, then a read racing zeroize
        rd_idx = 4'd12;
        tick();
        chk("idx12_err", 32'(rd_err), 32'd1);
        chk("idx12_data", rd_data, 32'd0);
        chk("idx12_valid", 32'(rd_valid), 32'd1);
        rd_idx = 4'd3; zeroize = 1'b1;
        tick();
        rd_req = 1'b0; zeroize = 1'b0;
        chk("zrace_data", rd_data, 32'hf2f1f0ef);
        chk("zrace_err", 32'(rd_err), 32'd0);
        chk("zrace_key_valid", 32'(key_valid), 32'd0);
        repeat (11) tick();
        chk("zsweep_key_valid", 32'(key_valid), 32'd0);
        tick();
        rd_req = 1'b1; rd_idx = 4'd0;
        tick();
        rd_req = 1'b0;
        chk("empty_rd_err", 32'(rd_err), 32'd1);
        chk("empty_rd_data", rd_data, 32'd0);

        // zeroize and load event together -> deferred load after the sweep
        kdf_complete = 1'b0;
        tick();
        kdf_session_key = key1; kdf_complete = 1'b1;
        tick();
        chk("load3_epoch", 32'(key_epoch), 32'd3);
        kdf_complete = 1'b0;
        tick();
        kdf_session_key = key2; kdf_complete = 1'b1; zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("pend_enter_valid", 32'(key_valid), 32'd0);
        repeat (11) tick();
        chk("pend_sweep_valid", 32'(key_valid), 32'd0);
        chk("pend_sweep_epoch", 32'(key_epoch), 32'd3);
        tick();
        chk("pend_load_valid", 32'(key_valid), 32'd1);
        chk("pend_load_epoch", 32'(key_epoch), 32'd4);
        rd_req = 1'b1; rd_idx = 4'd11;
        tick();
        rd_req = 1'b0;
        chk("pend_rd_w11", rd_data, 32'hd2d1d0cf);

        // lifetime expiry on the 20-cycle instance
        reset_n = 1'b0; kdf_complete = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        kdf_session_key = key1; kdf_complete = 1'b1;
        tick();
        chk("life_load_valid", 32'(key_valid_l), 32'd1);
        for (int k = 1; k <= 21; k++) begin
            tick();
            chk($sformatf("life_expired_c%0d", k), 32'(expired_l), 32'(k == 20));
            if (k == 19) chk("life_valid_c19", 32'(key_valid_l), 32'd1);
            if (k == 20) chk("life_valid_c20", 32'(key_valid_l), 32'd0);
        end
        repeat (11) tick();
        rd_req = 1'b1; rd_idx = 4'd0;
        tick();
        rd_req = 1'b0;
        chk("life_rd_err", 32'(rd_err_l), 32'd1);
        chk("life_rd_data", rd_data_l, 32'd0);
        chk("life_epoch", 32'(key_epoch_l), 32'd1);
        chk("nolife_rd_data", rd_data, 32'h01020304);

        // reset in the middle of a sweep, then epoch wrap
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0; kdf_complete = 1'b0;
        tick();
        chk("midz_reset_valid", 32'(key_valid), 32'd0);
        chk("midz_reset_epoch", 32'(key_epoch), 32'd0);
        reset_n = 1'b1; rd_req = 1'b1; rd_idx = 4'd0;
        tick();
        rd_req = 1'b0;
        chk("midz_rd_err", 32'(rd_err), 32'd1);
        chk("midz_rd_data", rd_data, 32'd0);
        for (int n = 0; n < 255; n++) begin
            kdf_complete = 1'b1;
            tick();
            kdf_complete = 1'b0;
            tick();
        end
        chk("wrap_epoch255", 32'(key_epoch), 32'd255);
        kdf_complete = 1'b1;
        tick();
        chk("wrap_epoch0", 32'(key_epoch), 32'd0);
        chk("wrap_valid", 32'(key_valid), 32'd1);
        rd_req = 1'b1; rd_idx = 4'd0;
        tick();
        rd_req = 1'b0;
        chk("wrap_rd_data", rd_data, 32'h01020304);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
